// File: rtl/scramble_sequencer_if.sv
// Bundle of the scramble sequencer's control, user pass-through and grid-drive signals.
// The slave modport faces the sequencer; the master modport faces whoever drives it.
interface scramble_sequencer_if;
  logic       start;
  logic       abort;
  logic [2:0] rand_in;
  logic [3:0] user_row_column;
  logic       user_nRow;
  logic       user_fire;
  logic [3:0] row_column;
  logic       x_nRow;
  logic       fire;
  logic       busy;
  logic       done;
  logic [7:0] moves_left;

  modport slave (
    input  start, abort, rand_in, user_row_column, user_nRow, user_fire,
    output row_column, x_nRow, fire, busy, done, moves_left
  );

  modport master (
    output start, abort, rand_in, user_row_column, user_nRow, user_fire,
    input  row_column, x_nRow, fire, busy, done, moves_left
  );
endinterface

// File: rtl/scramble_sequencer.sv
// Drives a sequence of random row/column moves into the cell grid, spaced by an idle gap,
// and passes user selections straight through while no scramble is running.
module scramble_sequencer #(
  parameter int NUM_MOVES  = 16,
  parameter int GAP_CYCLES = 1000,
  parameter int MAX_RETRY  = 3
) (
  input logic                  clk,
  input logic                  reset,
  scramble_sequencer_if.slave  bus
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_FIRE = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          r_state;
  logic [3:0]      r_row_column;
  logic            r_x_nrow;
  logic            r_fire;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_moves_left;
  logic [4:0]      r_prev;
  logic            r_prev_valid;
  logic [RW-1:0]   r_retry;
  logic [GW-1:0]   r_gap;

  logic [3:0]      w_line;
  logic            w_repeat;
  logic            w_retry;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] res;
    case (idx)
      2'd0:    res = 4'b0001;
      2'd1:    res = 4'b0010;
      2'd2:    res = 4'b0100;
      2'd3:    res = 4'b1000;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  // Decode the random sample and decide whether it must be redrawn.
  always_comb begin
    w_line   = onehot4(bus.rand_in[1:0]);
    w_repeat = r_prev_valid && (r_prev == {bus.rand_in[2], w_line});
    w_retry  = w_repeat && (r_retry < RW'(MAX_RETRY));
  end

  // Idle mirrors the user; reset forces the registered zeros through instead.
  always_comb begin
    if ((r_state == S_IDLE) && !reset) begin
      bus.row_column = bus.user_row_column;
      bus.x_nRow     = bus.user_nRow;
      bus.fire       = bus.user_fire;
    end else begin
      bus.row_column = r_row_column;
      bus.x_nRow     = r_x_nrow;
      bus.fire       = r_fire;
    end
    bus.busy       = r_busy;
    bus.done       = r_done;
    bus.moves_left = r_moves_left;
  end

  // Sequencer state machine with registered grid outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_row_column <= 4'b0000;
      r_x_nrow     <= 1'b0;
      r_fire       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_moves_left <= 8'd0;
      r_prev       <= 5'd0;
      r_prev_valid <= 1'b0;
      r_retry      <= '0;
      r_gap        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_fire <= 1'b0;
          r_done <= 1'b0;
          if (bus.start) begin
            r_state      <= S_LOAD;
            r_busy       <= 1'b1;
            r_moves_left <= 8'(NUM_MOVES);
            r_retry      <= '0;
            r_prev_valid <= 1'b0;
            r_row_column <= 4'b0000;
            r_x_nrow     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.abort) begin
            r_state      <= S_DONE;
            r_moves_left <= 8'd0;
            r_done       <= 1'b1;
          end else begin
            r_row_column <= w_line;
            r_x_nrow     <= bus.rand_in[2];
            if (w_retry) begin
              r_retry <= r_retry + RW'(1);
            end else begin
              r_state      <= S_FIRE;
              r_fire       <= 1'b1;
              r_prev       <= {bus.rand_in[2], w_line};
              r_prev_valid <= 1'b1;
            end
          end
        end
        S_FIRE: begin
          r_fire <= 1'b0;
          if (bus.abort) begin
            r_state      <= S_DONE;
            r_moves_left <= 8'd0;
            r_done       <= 1'b1;
          end else begin
            r_moves_left <= r_moves_left - 8'd1;
            if (r_moves_left > 8'd1) begin
              r_state <= S_GAP;
              r_gap   <= GW'(GAP_CYCLES - 1);
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (bus.abort) begin
            r_state      <= S_DONE;
            r_moves_left <= 8'd0;
            r_done       <= 1'b1;
          end else if (r_gap == '0) begin
            r_state <= S_LOAD;
            r_retry <= '0;
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_fire  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_fire  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scramble_sequencer.sv
// Scoreboard bench for scramble_sequencer with NUM_MOVES=4, GAP_CYCLES=3, MAX_RETRY=3.
module tb_scramble_sequencer;
  logic clk;
  logic reset;

  scramble_sequencer_if bus ();

  scramble_sequencer #(.NUM_MOVES(4), .GAP_CYCLES(3), .MAX_RETRY(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_fire = 0;
  int          fire_total = 0;
  int          fire_base  = 0;
  int          done_cnt   = 0;
  int          done_base  = 0;
  int          exp_gap    = 5;
  logic [2:0]  rand_tab [4];
  logic [12:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic push_moves(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({rand_tab[i][2], oh(rand_tab[i][1:0]), 8'(4 - i)});
  endtask

  // Monitor: compares each scramble fire pulse against the scoreboard and its spacing.
  always @(negedge clk) begin
    logic [12:0] e;
    int idx;
    cyc++;
    if (bus.done) done_cnt++;
    if (bus.fire && bus.busy) begin
      chk("fire_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("move", {bus.x_nRow, bus.row_column, bus.moves_left}, e);
      end
      if (fire_total > fire_base) chk("fire_spacing", cyc - last_fire, exp_gap);
      last_fire = cyc;
      fire_total++;
      idx = fire_total - fire_base;
      if (idx < 4) bus.rand_in = rand_tab[idx];
    end
  end

  task automatic wait_fires(input int n, input int budget);
    int k;
    k = 0;
    while (((fire_total - fire_base) < n) && (k < budget)) begin
      @(negedge clk); #1;
      k++;
    end
    chk("fire_wait", 32'((fire_total - fire_base) >= n), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while ((done_cnt <= done_base) && (k < budget)) begin
      @(negedge clk); #1;
      k++;
    end
    chk("done_wait", 32'(done_cnt > done_base), 32'd1);
  endtask

  task automatic start_scramble();
    fire_base = fire_total;
    done_base = done_cnt;
    bus.rand_in = rand_tab[0];
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("load_busy", bus.busy, 1'b1);
    chk("load_moves_left", bus.moves_left, 8'd4);
  endtask

  task automatic finish_checks(input int n_fires);
    chk("done_pulse", bus.done, 1'b1);
    chk("done_moves_left", bus.moves_left, 8'd0);
    chk("done_fire", bus.fire, 1'b0);
    chk("done_busy", bus.busy, 1'b1);
    @(negedge clk); #1;
    chk("done_one_cycle", bus.done, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
    chk("fire_count", fire_total - fire_base, n_fires);
    chk("done_count", done_cnt - done_base, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.rand_in = 3'b000;
    bus.user_row_column = 4'b1010;
    bus.user_nRow = 1'b1;
    bus.user_fire = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_row_column", bus.row_column, 4'b0000);
    chk("rst_x_nRow", bus.x_nRow, 1'b0);
    chk("rst_fire", bus.fire, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_moves_left", bus.moves_left, 8'd0);
    reset = 1'b0;
    bus.user_fire = 1'b0;

    // Idle pass-through.
    @(negedge clk);
    bus.user_row_column = 4'b0100;
    bus.user_nRow = 1'b1;
    bus.user_fire = 1'b1;
    #1;
    chk("pt_row_column", bus.row_column, 4'b0100);
    chk("pt_x_nRow", bus.x_nRow, 1'b1);
    chk("pt_fire", bus.fire, 1'b1);
    chk("pt_busy", bus.busy, 1'b0);
    @(negedge clk);
    bus.user_fire = 1'b0;
    #1;
    chk("pt_fire_low", bus.fire, 1'b0);
    bus.user_row_column = 4'b0000;
    bus.user_nRow = 1'b0;

    // Normal scramble with disturbances while busy.
    rand_tab = '{3'b000, 3'b101, 3'b010, 3'b111};
    exp_gap = 5;
    push_moves(4);
    start_scramble();
    wait_fires(1, 50);
    @(negedge clk);
    bus.start = 1'b1;
    bus.user_fire = 1'b1;
    bus.user_row_column = 4'b0010;
    bus.user_nRow = 1'b1;
    #1;
    chk("busy_row_column", bus.row_column, 4'b0001);
    chk("busy_x_nRow", bus.x_nRow, 1'b0);
    chk("busy_fire", bus.fire, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.user_fire = 1'b0;
    bus.user_row_column = 4'b0000;
    bus.user_nRow = 1'b0;
    wait_done(100);
    finish_checks(4);

    // Repeated sample forces the maximum retries on every later move.
    rand_tab = '{3'b011, 3'b011, 3'b011, 3'b011};
    exp_gap = 8;
    push_moves(4);
    start_scramble();
    wait_done(150);
    finish_checks(4);

    // Abort in the gap after the second fire.
    rand_tab = '{3'b000, 3'b101, 3'b010, 3'b111};
    exp_gap = 5;
    push_moves(2);
    start_scramble();
    wait_fires(2, 60);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    #1;
    chk("abort_done", bus.done, 1'b1);
    chk("abort_moves_left", bus.moves_left, 8'd0);
    chk("abort_fire", bus.fire, 1'b0);
    @(negedge clk);
    bus.user_row_column = 4'b1000;
    bus.user_fire = 1'b1;
    #1;
    chk("abort_pt_row_column", bus.row_column, 4'b1000);
    chk("abort_pt_fire", bus.fire, 1'b1);
    chk("abort_pt_busy", bus.busy, 1'b0);
    bus.user_fire = 1'b0;
    bus.user_row_column = 4'b0000;
    repeat (30) @(negedge clk);
    #1;
    chk("abort_fire_count", fire_total - fire_base, 2);
    chk("abort_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of a gap.
    push_moves(4);
    start_scramble();
    wait_fires(1, 50);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_row_column", bus.row_column, 4'b0000);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_moves_left", bus.moves_left, 8'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (6) @(negedge clk);
    #1;
    chk("mid_rst_no_done", done_cnt - done_base, 0);
    push_moves(4);
    start_scramble();
    wait_done(100);
    finish_checks(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/scramble_sequencer.md
SCRAMBLE_SEQUENCER -- requirements
Module: scramble_sequencer

Interface
REQ-001 The block SHALL have one clock `clk`; reset `reset` is asynchronous and active-high.
REQ-002 Parameter NUM_MOVES, default 16, SHALL set the number of fired moves per scramble (legal 1..255).
REQ-003 Parameter GAP_CYCLES, default 1000, SHALL set the idle cycles between fired moves (legal >= 1).
REQ-004 Parameter MAX_RETRY, default 3, SHALL set the maximum resamples when a move repeats the previous one.
REQ-005 Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- start  in  1  one-cycle pulse, begin scramble (already debounced/edge-detected)
- abort  in  1  one-cycle pulse, end scramble early
- rand_in  in  3  random source; bit2 = nRow, bits1:0 = line index
- user_row_column  in  4  validated one-hot user selection
- user_nRow  in  1  user row(0)/column(1) select
- user_fire  in  1  user fire
- row_column  out  4  one-hot line to the cell grid
- x_nRow  out  1  row(0)/column(1) select to the grid
- fire  out  1  fire to the grid
- busy  out  1  high while a scramble runs
- done  out  1  one-cycle pulse at scramble end
- moves_left  out  8  remaining moves

Function
REQ-006 The FSM SHALL have the states IDLE, LOAD, FIRE, GAP and DONE.
REQ-007 In IDLE, row_column, x_nRow and fire SHALL equal user_row_column, user_nRow and user_fire combinationally, with busy=0.
REQ-008 start in IDLE SHALL go to LOAD next edge and load moves_left=NUM_MOVES.
REQ-009 start outside IDLE SHALL be ignored.
REQ-010 When busy=1, user_* inputs SHALL be ignored.
REQ-011 LOAD SHALL register x_nRow=rand_in[2] and row_column=one-hot(rand_in[1:0]), with 00->0001, 01->0010, 10->0100 and 11->1000.
REQ-012 If a LOAD sample equals the previous fired move (same nRow and line), it SHALL stay in LOAD and resample next cycle, up to MAX_RETRY times, then accept.
REQ-013 The retry count SHALL clear on each entry to LOAD.
REQ-014 The first move of a scramble SHALL have no previous move, so no retry.
REQ-015 LOAD SHALL go to FIRE when a sample is accepted.
REQ-016 FIRE SHALL last exactly one cycle with fire=1, and row_column/x_nRow SHALL stay stable from LOAD through the end of GAP.
REQ-017 On leaving FIRE, moves_left SHALL decrement; the next state is GAP if the new value is greater than 0, else DONE.
REQ-018 GAP SHALL hold fire=0 for exactly GAP_CYCLES cycles, then go to LOAD.
REQ-019 DONE SHALL assert done=1 for one cycle with fire=0, busy=1 and moves_left=0, then go to IDLE.
REQ-020 abort in LOAD, FIRE or GAP SHALL go to DONE next edge, and SHALL take priority over every other transition.
REQ-021 On abort, moves_left SHALL clear to 0, and a fire already high in the abort cycle is not retracted.
REQ-022 abort in IDLE or DONE SHALL be ignored.
REQ-023 busy SHALL be 1 in LOAD, FIRE, GAP and DONE.
REQ-024 Exactly NUM_MOVES fire pulses SHALL occur per unaborted scramble.
REQ-025 There SHALL be exactly GAP_CYCLES+1+retries cycles between consecutive fire pulses.

Reset
REQ-026 While reset=1, the state SHALL be IDLE and all outputs 0 (row_column=0000, x_nRow=0, fire=0, busy=0, done=0, moves_left=0), overriding the pass-through.
REQ-027 Reset mid-scramble SHALL abandon the scramble without a done pulse.
REQ-028 The previous-move memory and retry count SHALL clear on reset.
REQ-029 After reset deasserts, the block SHALL wait in IDLE for start.

Verification (NUM_MOVES=4, GAP_CYCLES=3, MAX_RETRY=3)
REQ-030 Scenario: idle, user_row_column=0100, user_nRow=1, user_fire pulse -> outputs mirror the user inputs in the same cycle, busy=0.
REQ-031 Scenario: start with rand_in cycling 000,101,010,111 -> 4 fire pulses 5 cycles apart, moves 0001/row, 0010/col, 0100/row, 1000/col, moves_left 4->0, done one cycle, then IDLE.
REQ-032 Scenario: rand_in held at 011 after the first move -> 3 extra LOAD cycles, then 1000/row accepted; the spacing between pulses grows by 3.
REQ-033 Scenario: abort in the GAP after the 2nd fire -> done next cycle, moves_left=0, no further fire, user pass-through restored.
REQ-034 Scenario: start or user_fire during busy -> no effect on the pulse count or the outputs.
REQ-035 Scenario: reset asserted mid-GAP, asynchronously between edges -> outputs go to 0 immediately, no done pulse, and a new start after release runs a full 4 moves.
